// File: rtl/jtdd_prom_we.sv
// Download router: steers loader bytes to SDRAM (handshaked), to the priority
// PROM (single-cycle strobes), or drops them when they fall past the PROM window.
module jtdd_prom_we #(
    parameter logic [21:0] PROM_START = 22'h10_0000,
    parameter int          PROM_LEN   = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic [21:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [15:0] prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    input  logic        prog_rdy,
    output logic [7:0]  prom_addr,
    output logic [7:0]  prom_din,
    output logic        prom_prio_we,
    output logic        dwnld_busy,
    output logic        overflow
);

    localparam logic [0:0]  IDLE     = 1'b0;
    localparam logic [0:0]  SDWR     = 1'b1;
    localparam logic [22:0] PROM_END = 23'(PROM_START) + 23'(PROM_LEN);

    logic [0:0]  r_state;
    logic        r_buf_vld;
    logic [21:0] r_buf_addr;
    logic [7:0]  r_buf_data;

    logic        w_consume;
    logic        w_accept;
    logic        w_is_sdram;
    logic        w_is_prom;
    logic [21:0] w_off;

    assign w_consume  = r_buf_vld && (r_state == IDLE);
    assign w_accept   = downloading && ioctl_wr;
    assign w_is_sdram = r_buf_addr < PROM_START;
    assign w_is_prom  = !w_is_sdram && ({1'b0, r_buf_addr} < PROM_END);
    assign w_off      = r_buf_addr - PROM_START;

    // Busy is forced low while reset is held so every output reads 0 in reset.
    assign dwnld_busy = !rst && (downloading || r_buf_vld || (r_state != IDLE) || prom_prio_we);

    // One-entry skid buffer; a byte arriving while it is full and not draining is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_vld  <= 1'b0;
            r_buf_addr <= '0;
            r_buf_data <= '0;
            overflow   <= 1'b0;
        end else begin
            if (w_accept && (!r_buf_vld || w_consume)) begin
                r_buf_vld  <= 1'b1;
                r_buf_addr <= ioctl_addr;
                r_buf_data <= ioctl_data;
            end else if (w_consume) begin
                r_buf_vld  <= 1'b0;
            end
            if (w_accept && r_buf_vld && !w_consume)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            prog_addr    <= '0;
            prog_data    <= '0;
            prog_mask    <= '0;
            prog_we      <= 1'b0;
            prom_addr    <= '0;
            prom_din     <= '0;
            prom_prio_we <= 1'b0;
        end else begin
            prom_prio_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_consume) begin
                        if (w_is_sdram) begin
                            prog_addr <= {1'b0, r_buf_addr[21:1]};
                            prog_data <= {r_buf_data, r_buf_data};
                            prog_mask <= r_buf_addr[0] ? 2'b10 : 2'b01;
                            prog_we   <= 1'b1;
                            r_state   <= SDWR;
                        end else if (w_is_prom) begin
                            prom_addr    <= w_off[7:0];
                            prom_din     <= r_buf_data;
                            prom_prio_we <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (prog_rdy) begin
                        prog_we <= 1'b0;
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtdd_prom_we.sv
// Directed bench for jtdd_prom_we: SDRAM handshake, PROM streaming, discard,
// skid-buffer overflow, mid-transfer reset and end-of-download busy.
module tb_jtdd_prom_we;
    logic        clk = 1'b0;
    logic        rst;
    logic        downloading;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        prog_rdy;
    logic [7:0]  prom_addr;
    logic [7:0]  prom_din;
    logic        prom_prio_we;
    logic        dwnld_busy;
    logic        overflow;

    int n_chk  = 0;
    int n_fail = 0;

    jtdd_prom_we dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_we(prog_we), .prog_rdy(prog_rdy),
        .prom_addr(prom_addr), .prom_din(prom_din), .prom_prio_we(prom_prio_we),
        .dwnld_busy(dwnld_busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [21:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        tick(1);
        ioctl_wr   = 1'b0;
    endtask

    task automatic chk_sd(input string tag, input logic [21:0] a, input logic [15:0] d,
                          input logic [1:0] m);
        chk({tag, ".we"},   32'(prog_we),   32'd1);
        chk({tag, ".addr"}, 32'(prog_addr), 32'(a));
        chk({tag, ".data"}, 32'(prog_data), 32'(d));
        chk({tag, ".mask"}, 32'(prog_mask), 32'(m));
    endtask

    initial begin
        rst = 1'b1; downloading = 1'b0; ioctl_addr = '0; ioctl_data = '0;
        ioctl_wr = 1'b0; prog_rdy = 1'b0;
        tick(2);
        chk("rst.we", 32'(prog_we), 0);
        chk("rst.prio", 32'(prom_prio_we), 0);
        chk("rst.busy", 32'(dwnld_busy), 0);
        chk("rst.ovf", 32'(overflow), 0);
        chk("rst.addr", 32'(prog_addr), 0);
        rst = 1'b0;
        tick(1);

        // 1: odd SDRAM byte, delayed ack
        downloading = 1'b1;
        wr(22'h000005, 8'hA7);
        chk("t1.lat1", 32'(prog_we), 0);
        tick(1);
        chk_sd("t1", 22'h000002, 16'hA7A7, 2'b10);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk_sd("t1.hold", 22'h000002, 16'hA7A7, 2'b10);
        end
        prog_rdy = 1'b1;
        tick(1);
        prog_rdy = 1'b0;
        chk("t1.done", 32'(prog_we), 0);
        tick(2);

        // 2: 256 back-to-back PROM bytes
        for (int i = 0; i < 258; i++) begin
            if (i >= 2) begin
                chk("t2.prio", 32'(prom_prio_we), 1);
                chk("t2.addr", 32'(prom_addr), 32'(i - 2));
                chk("t2.din",  32'(prom_din),  32'((i - 2) & 3));
            end
            chk("t2.nowe", 32'(prog_we), 0);
            if (i < 256) begin
                ioctl_addr = 22'h100000 + 22'(i);
                ioctl_data = 8'(i & 3);
                ioctl_wr   = 1'b1;
            end else begin
                ioctl_wr   = 1'b0;
            end
            tick(1);
        end
        chk("t2.end", 32'(prom_prio_we), 0);
        chk("t2.ovf", 32'(overflow), 0);
        tick(1);

        // 3: long ack wait, one byte buffered, one dropped
        wr(22'h000010, 8'h11);
        tick(1);
        chk_sd("t3.a", 22'h000008, 16'h1111, 2'b01);
        wr(22'h000012, 8'h22);
        chk("t3.noovf", 32'(overflow), 0);
        wr(22'h000014, 8'h33);
        chk("t3.ovf", 32'(overflow), 1);
        tick(6);
        chk_sd("t3.wait", 22'h000008, 16'h1111, 2'b01);
        prog_rdy = 1'b1;
        tick(1);
        prog_rdy = 1'b0;
        chk("t3.ackd", 32'(prog_we), 0);
        tick(1);
        chk_sd("t3.b", 22'h000009, 16'h2222, 2'b01);
        prog_rdy = 1'b1;
        tick(1);
        prog_rdy = 1'b0;
        tick(3);
        chk("t3.nothird", 32'(prog_we), 0);
        chk("t3.ovfstk", 32'(overflow), 1);

        // 4: byte past the PROM window is discarded
        wr(22'h100100, 8'h55);
        for (int i = 0; i < 3; i++) begin
            chk("t4.nowe", 32'(prog_we), 0);
            chk("t4.noprio", 32'(prom_prio_we), 0);
            chk("t4.busy", 32'(dwnld_busy), 1);
            tick(1);
        end
        downloading = 1'b0;
        #1;
        chk("t4.idle", 32'(dwnld_busy), 0);
        tick(1);

        // 5: reset during SDRAM write
        downloading = 1'b1;
        wr(22'h000030, 8'h66);
        tick(1);
        chk("t5.we", 32'(prog_we), 1);
        rst = 1'b1;
        #1;
        chk("t5.we0", 32'(prog_we), 0);
        chk("t5.busy0", 32'(dwnld_busy), 0);
        chk("t5.ovf0", 32'(overflow), 0);
        tick(1);
        rst = 1'b0;
        downloading = 1'b0;
        tick(1);
        prog_rdy = 1'b1;
        tick(1);
        prog_rdy = 1'b0;
        tick(2);
        chk("t5.nowe", 32'(prog_we), 0);
        chk("t5.noprio", 32'(prom_prio_we), 0);
        chk("t5.busy", 32'(dwnld_busy), 0);

        // 6: downloading drops right after the last byte
        downloading = 1'b1;
        wr(22'h000020, 8'h5C);
        downloading = 1'b0;
        #1;
        chk("t6.busybuf", 32'(dwnld_busy), 1);
        tick(1);
        chk_sd("t6", 22'h000010, 16'h5C5C, 2'b01);
        tick(2);
        chk("t6.busyw", 32'(dwnld_busy), 1);
        prog_rdy = 1'b1;
        tick(1);
        prog_rdy = 1'b0;
        chk("t6.we0", 32'(prog_we), 0);
        chk("t6.busy0", 32'(dwnld_busy), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/jtdd_prom_we.md
Name: jtdd_prom_we

Overview:
Download router for the ROM loader stream. It steers each incoming byte in one of three ways:
- bytes below PROM_START go to SDRAM through a prog_we/prog_rdy handshake;
- bytes in the PROM window become single-cycle write pulses that fill the colour mixer's priority PROM (prog_addr/prom_prio_we side);
- bytes beyond the PROM window are discarded.

It sits between the framework download port and the SDRAM controller and colour mixer. It is the writer side of the priority PROM interface.

Parameters:
PROM_START, 22'h10_0000, first download byte address mapped to the priority PROM.
PROM_LEN, 256, PROM window size in bytes (addresses PROM_START..PROM_START+PROM_LEN-1).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active high
downloading  in  1  high while the loader stream is active
ioctl_addr  in  22  byte address of current download byte
ioctl_data  in  8  download byte
ioctl_wr  in  1  one-cycle strobe: byte valid
prog_addr  out  22  SDRAM word address (ioctl_addr>>1), zero-extended
prog_data  out  16  byte replicated on both halves {d,d}
prog_mask  out  2  byte enable, active high: bit0 = even byte, bit1 = odd byte
prog_we  out  1  SDRAM write request, held until acknowledged
prog_rdy  in  1  SDRAM acknowledge, one-cycle pulse
prom_addr  out  8  priority PROM address (drives colmix prog_addr)
prom_din  out  8  PROM data (colmix uses [1:0])
prom_prio_we  out  1  one-cycle PROM write strobe
dwnld_busy  out  1  high while downloading or any write pending
overflow  out  1  sticky: a byte was dropped because buffer was full

Behaviour:
Reset:
- All outputs 0; FSM in IDLE; skid buffer empty; overflow cleared.
- Asserted mid-transfer: the pending request is abandoned and prog_we drops immediately. No retry after reset release.

Address decode (on buffered byte):
- a < PROM_START -> SDRAM.
- PROM_START <= a < PROM_START+PROM_LEN -> PROM, with prom_addr = (a-PROM_START)[7:0].
- Otherwise -> discard; consumes one cycle, no output activity.

Input capture:
- One-entry skid buffer (addr, data, valid).
- ioctl_wr with buffer empty: load the buffer.
- ioctl_wr with buffer full and not being consumed this cycle: byte dropped, overflow set (sticky until reset).
- ioctl_wr in the same cycle the buffer is consumed: the new byte is accepted.
- ioctl_wr is ignored when downloading=0.

FSM:
- IDLE: on buffer valid, decode and consume the buffer.
  - SDRAM byte: register prog_addr/data/mask, prog_we<=1, go to SDWR.
  - PROM byte: register prom_addr/din, prom_prio_we<=1 for exactly one cycle, stay in IDLE.
  - Discard: stay in IDLE.
- SDWR: hold prog_we and all prog_* stable until prog_rdy=1. The cycle after prog_rdy, prog_we=0 and the FSM returns to IDLE.
  - prog_rdy seen in IDLE is ignored.
  - prog_rdy in the same cycle prog_we is first raised counts as acknowledge.

Latency:
- PROM byte: strobe 2 cycles after ioctl_wr (capture, then decode).
- SDRAM byte: prog_we 2 cycles after ioctl_wr.
- Back-to-back PROM bytes sustain one byte per cycle.

Mask and byte lane:
- ioctl_addr[0]=0 -> mask 2'b01; 1 -> 2'b10.
- prog_data is always {d,d}.

Busy and end of download:
- dwnld_busy = downloading | buffer valid | FSM not IDLE | prom_prio_we.
- A falling downloading edge with a write pending lets that write complete. dwnld_busy falls the cycle after it completes.

Wrap:
- PROM address is the 8-bit offset; no wrap beyond PROM_LEN because the decode excludes those bytes.

Test Plan:
1. Reset, downloading=1, ioctl_wr at addr 0x000005, data 0xA7 -> 2 cycles later prog_we=1, prog_addr=0x000002, prog_data=0xA7A7, prog_mask=2'b10. Hold prog_rdy=0 for 5 cycles: outputs stable. Pulse prog_rdy -> prog_we=0 next cycle.
2. Stream 256 bytes at PROM_START.. with data = i&3, one per cycle -> 256 single-cycle prom_prio_we pulses with prom_addr=0..255 and prom_din=i&3. No prog_we, overflow=0.
3. SDRAM byte at 0x10 with prog_rdy delayed 10 cycles; two more ioctl_wr during the wait -> first extra byte is buffered and written after the ack; second is dropped and overflow=1.
4. Byte at PROM_START+256 (0x100100) -> no prog_we, no prom_prio_we; dwnld_busy follows downloading only.
5. Assert rst while prog_we=1 in SDWR -> prog_we=0 immediately, dwnld_busy=0, overflow=0. After release, a prog_rdy pulse causes no activity.
6. Drop downloading the cycle after ioctl_wr to addr 0x20 -> write still issued; dwnld_busy falls the cycle after prog_rdy.
